// File: rtl/irq_priority_core.sv
// irq_priority_core: IRR/IMR/ISR storage, rotating-priority arbitration and
// OCW2 end-of-interrupt / rotation handling for an 8259A-compatible PIC.
module irq_priority_core #(
  parameter  int unsigned CHANNELS = 8,
  localparam int unsigned IDX_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                write_ICW_1,
  input  logic                write_OCW_1,
  input  logic                write_OCW_2,
  input  logic [7:0]          Internal_bus_data,
  input  logic [CHANNELS-1:0] interrupt_request_pins,
  input  logic                interrupt_ack,
  output logic [CHANNELS-1:0] Interrupt_Mask,
  output logic [CHANNELS-1:0] interrupt_request_reg,
  output logic [CHANNELS-1:0] in_service_reg,
  output logic                interrupt_out,
  output logic [IDX_W-1:0]    interrupt_vector_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(CHANNELS - 1);
  localparam logic [2:0]       CMD_NS_EOI  = 3'b001;
  localparam logic [2:0]       CMD_SP_EOI  = 3'b011;
  localparam logic [2:0]       CMD_ROT_NS  = 3'b101;
  localparam logic [2:0]       CMD_ROT_SP  = 3'b111;
  localparam logic [2:0]       CMD_SET_PRI = 3'b110;

  logic [CHANNELS-1:0] imr_q,  imr_d;
  logic [CHANNELS-1:0] irr_q,  irr_d;
  logic [CHANNELS-1:0] isr_q,  isr_d;
  logic [CHANNELS-1:0] prev_q, prev_d;
  logic [IDX_W-1:0]    ptr_q,  ptr_d;
  logic                ltim_q, ltim_d;
  logic                aeoi_q, aeoi_d;

  logic [CHANNELS-1:0] req;
  logic [IDX_W-1:0]    scan_pos;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [IDX_W-1:0]    win_rank;
  logic                isr_found;
  logic [IDX_W-1:0]    isr_idx;
  logic [IDX_W-1:0]    isr_rank;
  logic                int_pending;

  logic [2:0]          ocw2_cmd;
  logic [IDX_W-1:0]    ocw2_lvl;
  logic                lvl_ok;
  logic [CHANNELS-1:0] eoi_clr;
  logic                ptr_load;
  logic [IDX_W-1:0]    ptr_new;
  logic [CHANNELS-1:0] ack_set;
  logic [CHANNELS-1:0] edge_keep;

  // Only some bus bits matter for a given CHANNELS; fold the rest away.
  logic unused_bus_bits;
  assign unused_bus_bits = ^Internal_bus_data;

  // Channel visited at scan step k: order starts just after the lowest-priority pointer.
  function automatic logic [IDX_W-1:0] rot_pos(input logic [IDX_W-1:0] ptr,
                                               input int unsigned k);
    int unsigned p;
    p = 32'(ptr) + 32'd1 + k;
    if (p >= CHANNELS) p = p - CHANNELS;
    return IDX_W'(p);
  endfunction

  assign req = irr_q & ~imr_q;

  // Scan once in priority order, finding the top request and the top in-service bit.
  always_comb begin
    scan_pos  = '0;
    win_found = 1'b0;
    win_idx   = LAST_IDX;
    win_rank  = '0;
    isr_found = 1'b0;
    isr_idx   = LAST_IDX;
    isr_rank  = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      scan_pos = rot_pos(ptr_q, k);
      if (!win_found && req[scan_pos]) begin
        win_found = 1'b1;
        win_idx   = scan_pos;
        win_rank  = IDX_W'(k);
      end
      if (!isr_found && isr_q[scan_pos]) begin
        isr_found = 1'b1;
        isr_idx   = scan_pos;
        isr_rank  = IDX_W'(k);
      end
    end
  end

  assign int_pending = win_found & (~isr_found | (win_rank < isr_rank));

  assign ocw2_cmd = Internal_bus_data[7:5];
  assign ocw2_lvl = Internal_bus_data[IDX_W-1:0];
  assign lvl_ok   = (32'(ocw2_lvl) < CHANNELS);

  // OCW2 decode: which ISR bit to retire and where the pointer moves.
  always_comb begin
    eoi_clr  = '0;
    ptr_load = 1'b0;
    ptr_new  = ptr_q;
    if (write_OCW_2) begin
      unique case (ocw2_cmd)
        CMD_NS_EOI: begin
          if (isr_found) eoi_clr[isr_idx] = 1'b1;
        end
        CMD_ROT_NS: begin
          if (isr_found) begin
            eoi_clr[isr_idx] = 1'b1;
            ptr_load         = 1'b1;
            ptr_new          = isr_idx;
          end
        end
        CMD_SP_EOI: begin
          if (lvl_ok && isr_q[ocw2_lvl]) eoi_clr[ocw2_lvl] = 1'b1;
        end
        CMD_ROT_SP: begin
          if (lvl_ok && isr_q[ocw2_lvl]) begin
            eoi_clr[ocw2_lvl] = 1'b1;
            ptr_load          = 1'b1;
            ptr_new           = ocw2_lvl;
          end
        end
        CMD_SET_PRI: begin
          if (lvl_ok) begin
            ptr_load = 1'b1;
            ptr_new  = ocw2_lvl;
          end
        end
        default: ;
      endcase
    end
  end

  // Acknowledge only acts when a winner exists; otherwise it is spurious.
  assign ack_set = (interrupt_ack && win_found) ? (CHANNELS'(1) << win_idx) : '0;

  // Edge mode: a high pin keeps an already latched bit or sets it after a low sample.
  assign edge_keep = ltim_q ? '1 : (irr_q | ~prev_q);

  always_comb begin
    imr_d  = write_OCW_1 ? Internal_bus_data[CHANNELS-1:0] : imr_q;
    irr_d  = interrupt_request_pins & edge_keep & ~ack_set;
    isr_d  = (isr_q & ~eoi_clr) | (aeoi_q ? '0 : ack_set);
    prev_d = interrupt_request_pins;
    ptr_d  = ptr_load ? ptr_new : ptr_q;
    ltim_d = ltim_q;
    aeoi_d = aeoi_q;
    if (write_ICW_1) begin
      imr_d  = '0;
      irr_d  = '0;
      isr_d  = '0;
      prev_d = '0;
      ptr_d  = LAST_IDX;
      ltim_d = Internal_bus_data[3];
      aeoi_d = Internal_bus_data[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imr_q  <= '0;
      irr_q  <= '0;
      isr_q  <= '0;
      prev_q <= '0;
      ptr_q  <= LAST_IDX;
      ltim_q <= 1'b0;
      aeoi_q <= 1'b0;
    end else begin
      imr_q  <= imr_d;
      irr_q  <= irr_d;
      isr_q  <= isr_d;
      prev_q <= prev_d;
      ptr_q  <= ptr_d;
      ltim_q <= ltim_d;
      aeoi_q <= aeoi_d;
    end
  end

  assign Interrupt_Mask        = imr_q;
  assign interrupt_request_reg = irr_q;
  assign in_service_reg        = isr_q;
  assign interrupt_out         = int_pending;
  assign interrupt_vector_idx  = win_idx;

endmodule

// File: tb/tb_irq_priority_core.sv
// Bench for irq_priority_core: 8- and 4-channel instances share stimulus and are
// compared every cycle against a rank-arithmetic reference model.
module tb_irq_priority_core;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       icw1, ocw1, ocw2, ack;
  logic [7:0] data;
  logic [7:0] pins;

  logic [7:0] imr8, irr8, isr8;
  logic       int8;
  logic [2:0] idx8;
  logic [3:0] imr4, irr4, isr4;
  logic       int4;
  logic [1:0] idx4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  irq_priority_core #(.CHANNELS(8)) u8 (
    .clk(clk), .reset_n(reset_n), .write_ICW_1(icw1), .write_OCW_1(ocw1),
    .write_OCW_2(ocw2), .Internal_bus_data(data), .interrupt_request_pins(pins),
    .interrupt_ack(ack), .Interrupt_Mask(imr8), .interrupt_request_reg(irr8),
    .in_service_reg(isr8), .interrupt_out(int8), .interrupt_vector_idx(idx8)
  );

  irq_priority_core #(.CHANNELS(4)) u4 (
    .clk(clk), .reset_n(reset_n), .write_ICW_1(icw1), .write_OCW_1(ocw1),
    .write_OCW_2(ocw2), .Internal_bus_data(data), .interrupt_request_pins(pins[3:0]),
    .interrupt_ack(ack), .Interrupt_Mask(imr4), .interrupt_request_reg(irr4),
    .in_service_reg(isr4), .interrupt_out(int4), .interrupt_vector_idx(idx4)
  );

  typedef struct {
    int imr;
    int irr;
    int isr;
    int prev;
    int ptr;
    bit ltim;
    bit aeoi;
  } ms_t;

  ms_t m8, m4;

  function automatic ms_t rst_state(int n);
    ms_t r;
    r.imr = 0; r.irr = 0; r.isr = 0; r.prev = 0;
    r.ptr = n - 1; r.ltim = 1'b0; r.aeoi = 1'b0;
    return r;
  endfunction

  // Rank 0 is the highest priority: the channel right after the pointer.
  function automatic int rank_of(int n, int ptr, int ch);
    return (ch - ptr - 1 + 2 * n) % n;
  endfunction

  function automatic int best(int n, int ptr, int bits);
    int b = -1;
    for (int ch = 0; ch < n; ch++)
      if (((bits >> ch) & 1) != 0)
        if (b < 0 || rank_of(n, ptr, ch) < rank_of(n, ptr, b)) b = ch;
    return b;
  endfunction

  function automatic int exp_idx(int n, ms_t s);
    int w = best(n, s.ptr, s.irr & ~s.imr);
    return (w < 0) ? n - 1 : w;
  endfunction

  function automatic int exp_int(int n, ms_t s);
    int w = best(n, s.ptr, s.irr & ~s.imr);
    int t = best(n, s.ptr, s.isr);
    if (w < 0) return 0;
    if (t < 0) return 1;
    return (rank_of(n, s.ptr, w) < rank_of(n, s.ptr, t)) ? 1 : 0;
  endfunction

  function automatic ms_t step(int n, ms_t s, bit i1, bit o1, bit o2, bit ak, int d, int pn);
    ms_t r;
    int full, w, ackm, lm, lvl, cmd, top, clr;
    full = (1 << n) - 1;
    pn   = pn & full;
    if (i1) begin
      r = rst_state(n);
      r.ltim = d[3];
      r.aeoi = d[1];
      return r;
    end
    r = s;
    w = best(n, s.ptr, s.irr & ~s.imr);
    ackm = (ak && w >= 0) ? (1 << w) : 0;
    r.prev = pn;
    r.irr = 0;
    for (int ch = 0; ch < n; ch++) begin
      bit pin_hi, was_hi, held;
      pin_hi = ((pn >> ch) & 1) != 0;
      was_hi = ((s.prev >> ch) & 1) != 0;
      held   = ((s.irr >> ch) & 1) != 0;
      if (pin_hi && (s.ltim || !was_hi || held)) r.irr = r.irr | (1 << ch);
    end
    r.irr = r.irr & ~ackm;
    if (o1) r.imr = d & full;
    lm = 1;
    while (lm + 1 < n) lm = lm * 2 + 1;
    lvl = d & lm;
    cmd = (d >> 5) & 7;
    top = best(n, s.ptr, s.isr);
    clr = 0;
    if (o2) begin
      case (cmd)
        1: if (top >= 0) clr = 1 << top;
        5: if (top >= 0) begin clr = 1 << top; r.ptr = top; end
        3: if (lvl < n && ((s.isr >> lvl) & 1) != 0) clr = 1 << lvl;
        7: if (lvl < n && ((s.isr >> lvl) & 1) != 0) begin clr = 1 << lvl; r.ptr = lvl; end
        6: if (lvl < n) r.ptr = lvl;
        default: ;
      endcase
    end
    r.isr = (s.isr & ~clr) | (s.aeoi ? 0 : ackm);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input int expv);
    total++;
    assert (obs === 32'(expv)) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".imr8"}, 32'(imr8), m8.imr);
    chk({tag, ".irr8"}, 32'(irr8), m8.irr);
    chk({tag, ".isr8"}, 32'(isr8), m8.isr);
    chk({tag, ".int8"}, 32'(int8), exp_int(8, m8));
    chk({tag, ".idx8"}, 32'(idx8), exp_idx(8, m8));
    chk({tag, ".imr4"}, 32'(imr4), m4.imr);
    chk({tag, ".irr4"}, 32'(irr4), m4.irr);
    chk({tag, ".isr4"}, 32'(isr4), m4.isr);
    chk({tag, ".int4"}, 32'(int4), exp_int(4, m4));
    chk({tag, ".idx4"}, 32'(idx4), exp_idx(4, m4));
  endtask

  // One clock: model steps on pre-edge inputs, strobes drop, outputs checked.
  task automatic cycle(input string tag);
    ms_t n8, n4;
    n8 = step(8, m8, icw1, ocw1, ocw2, ack, int'(data), int'(pins));
    n4 = step(4, m4, icw1, ocw1, ocw2, ack, int'(data), int'(pins));
    @(posedge clk);
    m8 = n8;
    m4 = n4;
    #1;
    icw1 = 1'b0; ocw1 = 1'b0; ocw2 = 1'b0; ack = 1'b0;
    check_all(tag);
  endtask

  // Mid-cycle asynchronous reset pulse.
  task automatic do_reset(input string tag);
    #3 reset_n = 1'b0;
    #1;
    m8 = rst_state(8);
    m4 = rst_state(4);
    check_all(tag);
    chk({tag, ".z_irr8"}, 32'(irr8), 0);
    chk({tag, ".z_isr8"}, 32'(isr8), 0);
    chk({tag, ".z_int8"}, 32'(int8), 0);
    @(posedge clk);
    #1;
    icw1 = 1'b0; ocw1 = 1'b0; ocw2 = 1'b0; ack = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    icw1 = 1'b0; ocw1 = 1'b0; ocw2 = 1'b0; ack = 1'b0;
    data = 8'h00; pins = 8'h00;
    m8 = rst_state(8);
    m4 = rst_state(4);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset.idx8_const", 32'(idx8), 7);
    chk("reset.idx4_const", 32'(idx4), 3);
    reset_n = 1'b1;

    // Basic request / ack / EOI flow
    data = 8'h00; icw1 = 1'b1; cycle("icw1");
    data = 8'h00; ocw1 = 1'b1; cycle("ocw1");
    repeat (2) cycle("idle");
    pins[3] = 1'b1; cycle("pin3");
    chk("pin3.irr", 32'(irr8), 'h08);
    chk("pin3.int", 32'(int8), 1);
    chk("pin3.idx", 32'(idx8), 3);
    ack = 1'b1; cycle("ack3");
    chk("ack3.isr", 32'(isr8), 'h08);
    chk("ack3.irr", 32'(irr8), 'h00);
    chk("ack3.int", 32'(int8), 0);
    pins = 8'h00; ocw2 = 1'b1; data = 8'h20; cycle("eoi3");
    chk("eoi3.isr", 32'(isr8), 'h00);

    pins = 8'h24; cycle("p25");
    chk("p25.idx", 32'(idx8), 2);
    ack = 1'b1; cycle("ack2");
    chk("ack2.isr", 32'(isr8), 'h04);
    chk("ack2.int", 32'(int8), 0);
    ocw2 = 1'b1; data = 8'h20; cycle("eoi2");
    chk("eoi2.isr", 32'(isr8), 'h00);
    chk("eoi2.int", 32'(int8), 1);
    chk("eoi2.idx", 32'(idx8), 5);

    // Masking
    pins[2] = 1'b0; cycle("p2lo");
    pins[2] = 1'b1; cycle("p2hi");
    ocw1 = 1'b1; data = 8'h04; cycle("mask04");
    chk("mask04.idx", 32'(idx8), 5);
    chk("mask04.irr", 32'(irr8), 'h24);
    ocw1 = 1'b1; data = 8'h24; cycle("mask24");
    chk("mask24.int", 32'(int8), 0);
    chk("mask24.irr", 32'(irr8), 'h24);

    // Rotation
    ocw1 = 1'b1; data = 8'h00; pins = 8'h00; cycle("unmask");
    pins = 8'h02; cycle("p1");
    ack = 1'b1; cycle("ack1");
    chk("ack1.isr", 32'(isr8), 'h02);
    ocw2 = 1'b1; data = 8'hA0; cycle("rotns");
    chk("rotns.isr", 32'(isr8), 'h00);
    pins = 8'h05; cycle("p02");
    chk("p02.idx", 32'(idx8), 2);
    ocw2 = 1'b1; data = 8'hC7; cycle("setpri");
    chk("setpri.idx", 32'(idx8), 0);
    chk("setpri.idx4", 32'(idx4), 0);

    // Level vs edge vs auto-EOI
    pins = 8'h00; data = 8'h08; icw1 = 1'b1; cycle("lvl");
    pins = 8'h10; cycle("lvl.p4");
    chk("lvl.irr", 32'(irr8), 'h10);
    ack = 1'b1; cycle("lvl.ack");
    chk("lvl.ack_irr", 32'(irr8), 'h00);
    cycle("lvl.refire");
    chk("lvl.refire_irr", 32'(irr8), 'h10);
    data = 8'h00; icw1 = 1'b1; cycle("edge");
    cycle("edge.set");
    chk("edge.set_irr", 32'(irr8), 'h10);
    ack = 1'b1; cycle("edge.ack");
    repeat (3) cycle("edge.hold");
    chk("edge.hold_irr", 32'(irr8), 'h00);
    pins = 8'h00; cycle("edge.lo");
    pins = 8'h10; cycle("edge.re");
    chk("edge.re_irr", 32'(irr8), 'h10);
    data = 8'h02; icw1 = 1'b1; cycle("aeoi");
    cycle("aeoi.set");
    ack = 1'b1; cycle("aeoi.ack");
    chk("aeoi.isr", 32'(isr8), 'h00);
    chk("aeoi.irr", 32'(irr8), 'h00);

    // Boundaries
    pins = 8'h00; data = 8'h00; icw1 = 1'b1; cycle("spur.init");
    ack = 1'b1; cycle("spur.ack");
    chk("spur.idx", 32'(idx8), 7);
    chk("spur.isr", 32'(isr8), 'h00);
    ocw2 = 1'b1; data = 8'h60; cycle("eoi_empty");
    chk("eoi_empty.isr", 32'(isr8), 'h00);
    pins = 8'h0C; cycle("p23");
    ack = 1'b1; cycle("p23.ack2");
    ack = 1'b1; cycle("p23.ack3");
    chk("p23.isr4", 32'(isr4), 'hC);
    ocw2 = 1'b1; data = 8'h66; cycle("sp66");
    chk("sp66.isr4", 32'(isr4), 'h8);
    chk("sp66.isr8", 32'(isr8), 'h0C);
    ocw2 = 1'b1; data = 8'h67; cycle("sp67");
    chk("sp67.isr4", 32'(isr4), 'h0);
    pins = 8'h01; cycle("pend");
    ack = 1'b1;
    do_reset("rst_ack");
    pins = 8'h00;
    cycle("post_rst");

    // Randomized traffic
    for (int it = 0; it < 800; it++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 5) == 0) pins[b] = ~pins[b];
      ack  = ($urandom_range(0, 3) == 0);
      ocw1 = ($urandom_range(0, 11) == 0);
      ocw2 = ($urandom_range(0, 4) == 0);
      icw1 = ($urandom_range(0, 79) == 0);
      data = 8'($urandom);
      if (ocw1 && $urandom_range(0, 1) == 0) data = data & 8'($urandom);
      if ($urandom_range(0, 249) == 0) begin
        pins = 8'h00;
        do_reset("rnd_rst");
      end else begin
        cycle("rnd");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
